// File: rtl/envm_pkg.sv
// Shared encodings for the embedded-NVM pattern store: write kinds, pattern
// fields, program FSM states and test-type constants.
package envm_pkg;

   typedef enum logic [1:0] {
      WR_PATTERN  = 2'd0,
      WR_FAULT    = 2'd1,
      WR_ERASE    = 2'd2,
      WR_RESERVED = 2'd3
   } wr_kind_e;

   localparam logic [2:0] FLD_WT1     = 3'd0;
   localparam logic [2:0] FLD_WT2     = 3'd1;
   localparam logic [2:0] FLD_ACT1    = 3'd2;
   localparam logic [2:0] FLD_ACT2    = 3'd3;
   localparam logic [2:0] FLD_PSUM1   = 3'd4;
   localparam logic [2:0] FLD_PSUM2   = 3'd5;
   localparam logic [2:0] FLD_ANSWER  = 3'd6;
   localparam logic [2:0] FLD_CAPTURE = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PROG,
      ST_COMMIT
   } prog_state_e;

   localparam logic TEST_SA = 1'b0;
   localparam logic TEST_TD = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/envm_popcount.sv
// Combinational population count of the flattened PE fault map.
module envm_popcount #(
   parameter int WIDTH = 64,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] bits_i,
   output logic [CNT_W-1:0] count_o
);

   always_comb begin
      count_o = '0;
      // NOTE: blocking '=' is correct here: the loop accumulates into count_o
      // within one evaluation; sequential state elsewhere uses '<='.
      for (int i = 0; i < WIDTH; i++) begin
         count_o = count_o + CNT_W'(bits_i[i]);
      end
   end

endmodule

// File: rtl/envm_pattern_store.sv
// Run-time loadable SA/TD scan-pattern store with fault maps and a multi-cycle
// program handshake. Define ENVM_FAULT_ACCUM_EN to OR fault records into the maps.
module envm_pattern_store
   import envm_pkg::*;
#(
   parameter int SYSTOLIC_SIZE     = 8,
   parameter int WEIGHT_WIDTH      = 8,
   parameter int ACTIVATION_WIDTH  = 8,
   parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
   parameter int SA_DEPTH          = 12,
   parameter int TD_DEPTH          = 18,
   parameter int PROG_CYCLES       = 4,
   parameter int ADDR_WIDTH        = $clog2(SYSTOLIC_SIZE),
   parameter int PAT_ADDR_WIDTH    = $clog2(max_int(SA_DEPTH, TD_DEPTH))
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic                                              wr_valid,
   output logic                                              wr_ready,
   input  logic [1:0]                                        wr_kind,
   input  logic                                              wr_type,
   input  logic [2:0]                                        wr_field,
   input  logic [PAT_ADDR_WIDTH-1:0]                         wr_addr,
   input  logic [PARTIAL_SUM_WIDTH-1:0]                      wr_data,
   input  logic [SYSTOLIC_SIZE-1:0]                          wr_pe_fault,
   input  logic                                              wr_row_fault,
   input  logic                                              wr_col_fault,
   input  logic                                              rd_req,
   input  logic                                              test_type,
   input  logic                                              td_answer_choose,
   input  logic [PAT_ADDR_WIDTH-1:0]                         test_counter,
   output logic                                              rd_valid,
   output logic                                              rd_err,
   output logic [WEIGHT_WIDTH-1:0]                           scan_data_weight,
   output logic [ACTIVATION_WIDTH-1:0]                       scan_data_activation,
   output logic [PARTIAL_SUM_WIDTH-1:0]                      scan_data_partial_sum_in,
   output logic [PARTIAL_SUM_WIDTH-1:0]                      scan_data_answer,
   output logic                                              busy,
   output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0]            envm_faulty_patterns_flat,
   output logic [SYSTOLIC_SIZE-1:0]                          faulty_row_flat,
   output logic [SYSTOLIC_SIZE-1:0]                          faulty_column_flat,
   output logic [$clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)-1:0]  faulty_pe_count
);

   localparam int N      = SYSTOLIC_SIZE;
   localparam int WW     = WEIGHT_WIDTH;
   localparam int AW     = ACTIVATION_WIDTH;
   localparam int PSW    = PARTIAL_SUM_WIDTH;
   localparam int PC_W   = $clog2(N * N + 1);
   localparam int PROG_W = $clog2(PROG_CYCLES + 1);
   localparam int SA_IW  = (SA_DEPTH > 1) ? $clog2(SA_DEPTH) : 1;
   localparam int TD_IW  = (TD_DEPTH > 1) ? $clog2(TD_DEPTH) : 1;

   prog_state_e               state_q, state_d;
   logic [PROG_W-1:0]         cnt_q, cnt_d;
   wr_kind_e                  kind_q;
   logic                      type_q;
   logic [2:0]                field_q;
   logic [PAT_ADDR_WIDTH-1:0] addr_q;
   logic [PSW-1:0]            data_q;
   logic [N-1:0]              pe_q;
   logic                      rowf_q, colf_q;

   assign wr_ready = (state_q == ST_IDLE);
   assign busy     = (state_q != ST_IDLE);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: if (wr_valid) begin
            state_d = ST_PROG;
            cnt_d   = PROG_W'(PROG_CYCLES - 1);
         end
         ST_PROG: if (cnt_q == '0) state_d = ST_COMMIT;
                  else             cnt_d   = cnt_q - PROG_W'(1);
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         kind_q  <= WR_PATTERN;
         type_q  <= TEST_SA;
         field_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         pe_q    <= '0;
         rowf_q  <= 1'b0;
         colf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (wr_valid && wr_ready) begin
            kind_q  <= wr_kind_e'(wr_kind);
            type_q  <= wr_type;
            field_q <= wr_field;
            addr_q  <= wr_addr;
            data_q  <= wr_data;
            pe_q    <= wr_pe_fault;
            rowf_q  <= wr_row_fault;
            colf_q  <= wr_col_fault;
         end
      end
   end

   logic commit, sa_wr, td_wr;
   assign commit = (state_q == ST_COMMIT);
   assign sa_wr  = commit && kind_q == WR_PATTERN && type_q == TEST_SA && int'(addr_q) < SA_DEPTH;
   assign td_wr  = commit && kind_q == WR_PATTERN && type_q == TEST_TD && int'(addr_q) < TD_DEPTH;

   logic [WW-1:0]  sa_wt1_mem   [SA_DEPTH];
   logic [AW-1:0]  sa_act1_mem  [SA_DEPTH];
   logic [PSW-1:0] sa_psum1_mem [SA_DEPTH];
   logic [PSW-1:0] sa_ans_mem   [SA_DEPTH];
   logic [WW-1:0]  td_wt2_mem   [TD_DEPTH];
   logic [AW-1:0]  td_act1_mem  [TD_DEPTH];
   logic [AW-1:0]  td_act2_mem  [TD_DEPTH];
   logic [PSW-1:0] td_psum1_mem [TD_DEPTH];
   logic [PSW-1:0] td_psum2_mem [TD_DEPTH];
   logic [PSW-1:0] td_launch_mem[TD_DEPTH];
   logic [PSW-1:0] td_capt_mem  [TD_DEPTH];

   // NOTE: pattern arrays have no reset; they model retained NVM content and
   // a reset clause would also turn them into flops instead of a RAM.
   always_ff @(posedge clk) begin
      if (sa_wr) begin
         case (field_q)
            FLD_WT1:    sa_wt1_mem  [addr_q[SA_IW-1:0]] <= data_q[WW-1:0];
            FLD_ACT1:   sa_act1_mem [addr_q[SA_IW-1:0]] <= data_q[AW-1:0];
            FLD_PSUM1:  sa_psum1_mem[addr_q[SA_IW-1:0]] <= data_q;
            FLD_ANSWER: sa_ans_mem  [addr_q[SA_IW-1:0]] <= data_q;
            default: ;
         endcase
      end
      // TD wt1 is accepted but never driven onto the scan outputs, so it is not kept.
      if (td_wr) begin
         case (field_q)
            FLD_WT2:     td_wt2_mem   [addr_q[TD_IW-1:0]] <= data_q[WW-1:0];
            FLD_ACT1:    td_act1_mem  [addr_q[TD_IW-1:0]] <= data_q[AW-1:0];
            FLD_ACT2:    td_act2_mem  [addr_q[TD_IW-1:0]] <= data_q[AW-1:0];
            FLD_PSUM1:   td_psum1_mem [addr_q[TD_IW-1:0]] <= data_q;
            FLD_PSUM2:   td_psum2_mem [addr_q[TD_IW-1:0]] <= data_q;
            FLD_ANSWER:  td_launch_mem[addr_q[TD_IW-1:0]] <= data_q;
            FLD_CAPTURE: td_capt_mem  [addr_q[TD_IW-1:0]] <= data_q;
            default: ;
         endcase
      end
   end

   logic [N*N-1:0]        pe_map_q;
   logic [N-1:0]          row_map_q, col_map_q;
   logic [PC_W-1:0]       pe_cnt_q, pe_cnt_d;
   logic [ADDR_WIDTH-1:0] frow;
   assign frow = addr_q[ADDR_WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pe_map_q  <= '0;
         row_map_q <= '0;
         col_map_q <= '0;
         pe_cnt_q  <= '0;
      end else begin
         pe_cnt_q <= pe_cnt_d;
         if (commit && kind_q == WR_ERASE) begin
            pe_map_q  <= '0;
            row_map_q <= '0;
            col_map_q <= '0;
         end else if (commit && kind_q == WR_FAULT) begin
`ifdef ENVM_FAULT_ACCUM_EN
            pe_map_q[int'(frow)*N +: N] <= pe_map_q[int'(frow)*N +: N] | pe_q;
            row_map_q[frow]             <= row_map_q[frow] | rowf_q;
            col_map_q[frow]             <= col_map_q[frow] | colf_q;
`else
            pe_map_q[int'(frow)*N +: N] <= pe_q;
            row_map_q[frow]             <= rowf_q;
            col_map_q[frow]             <= colf_q;
`endif
         end
      end
   end

   envm_popcount #(.WIDTH(N * N), .CNT_W(PC_W)) u_popcount (
      .bits_i  (pe_map_q),
      .count_o (pe_cnt_d)
   );

   assign envm_faulty_patterns_flat = pe_map_q;
   assign faulty_row_flat           = row_map_q;
   assign faulty_column_flat        = col_map_q;
   assign faulty_pe_count           = pe_cnt_q;

   logic           rd_err_d, rd_valid_q, rd_err_q;
   logic [WW-1:0]  rd_wt_d, rd_wt_q;
   logic [AW-1:0]  rd_act_d, rd_act_q;
   logic [PSW-1:0] rd_ps_d, rd_ps_q, rd_ans_d, rd_ans_q;

   // TD capture uses act1/psum1 with the capture answer; launch uses act2/psum2.
   always_comb begin
      rd_err_d = 1'b0;
      rd_wt_d  = '0;
      rd_act_d = '0;
      rd_ps_d  = '0;
      rd_ans_d = '0;
      if (test_type == TEST_SA) begin
         if (int'(test_counter) < SA_DEPTH) begin
            rd_wt_d  = sa_wt1_mem  [test_counter[SA_IW-1:0]];
            rd_act_d = sa_act1_mem [test_counter[SA_IW-1:0]];
            rd_ps_d  = sa_psum1_mem[test_counter[SA_IW-1:0]];
            rd_ans_d = sa_ans_mem  [test_counter[SA_IW-1:0]];
         end else begin
            rd_err_d = 1'b1;
         end
      end else if (int'(test_counter) < TD_DEPTH) begin
         rd_wt_d = td_wt2_mem[test_counter[TD_IW-1:0]];
         if (td_answer_choose) begin
            rd_act_d = td_act1_mem [test_counter[TD_IW-1:0]];
            rd_ps_d  = td_psum1_mem[test_counter[TD_IW-1:0]];
            rd_ans_d = td_capt_mem [test_counter[TD_IW-1:0]];
         end else begin
            rd_act_d = td_act2_mem  [test_counter[TD_IW-1:0]];
            rd_ps_d  = td_psum2_mem [test_counter[TD_IW-1:0]];
            rd_ans_d = td_launch_mem[test_counter[TD_IW-1:0]];
         end
      end else begin
         rd_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_wt_q    <= '0;
         rd_act_q   <= '0;
         rd_ps_q    <= '0;
         rd_ans_q   <= '0;
      end else begin
         rd_valid_q <= rd_req;
         rd_err_q   <= rd_req & rd_err_d;
         if (rd_req) begin
            rd_wt_q  <= rd_wt_d;
            rd_act_q <= rd_act_d;
            rd_ps_q  <= rd_ps_d;
            rd_ans_q <= rd_ans_d;
         end
      end
   end

   assign rd_valid                 = rd_valid_q;
   assign rd_err                   = rd_err_q;
   assign scan_data_weight         = rd_wt_q;
   assign scan_data_activation     = rd_act_q;
   assign scan_data_partial_sum_in = rd_ps_q;
   assign scan_data_answer         = rd_ans_q;

endmodule

// File: tb/tb_envm_pattern_store.sv
// Self-checking bench for envm_pattern_store: table-driven pattern loads and
// reads with a read scoreboard, plus hand sequences for program timing and reset.
module tb_envm_pattern_store;

   localparam int N    = 8;
   localparam int PSW  = 19;
   localparam int PW   = 5;
   localparam int PC_W = 7;
   localparam int PROG = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            wr_valid, wr_ready;
   logic [1:0]      wr_kind;
   logic            wr_type;
   logic [2:0]      wr_field;
   logic [PW-1:0]   wr_addr;
   logic [PSW-1:0]  wr_data;
   logic [N-1:0]    wr_pe_fault;
   logic            wr_row_fault, wr_col_fault;
   logic            rd_req, test_type, td_answer_choose;
   logic [PW-1:0]   test_counter;
   logic            rd_valid, rd_err, busy;
   logic [7:0]      scan_data_weight, scan_data_activation;
   logic [PSW-1:0]  scan_data_partial_sum_in, scan_data_answer;
   logic [N*N-1:0]  envm_faulty_patterns_flat;
   logic [N-1:0]    faulty_row_flat, faulty_column_flat;
   logic [PC_W-1:0] faulty_pe_count;

   always #5 clk = ~clk;

   envm_pattern_store dut (
      .clk                       (clk),
      .rst                       (rst),
      .wr_valid                  (wr_valid),
      .wr_ready                  (wr_ready),
      .wr_kind                   (wr_kind),
      .wr_type                   (wr_type),
      .wr_field                  (wr_field),
      .wr_addr                   (wr_addr),
      .wr_data                   (wr_data),
      .wr_pe_fault               (wr_pe_fault),
      .wr_row_fault              (wr_row_fault),
      .wr_col_fault              (wr_col_fault),
      .rd_req                    (rd_req),
      .test_type                 (test_type),
      .td_answer_choose          (td_answer_choose),
      .test_counter              (test_counter),
      .rd_valid                  (rd_valid),
      .rd_err                    (rd_err),
      .scan_data_weight          (scan_data_weight),
      .scan_data_activation      (scan_data_activation),
      .scan_data_partial_sum_in  (scan_data_partial_sum_in),
      .scan_data_answer          (scan_data_answer),
      .busy                      (busy),
      .envm_faulty_patterns_flat (envm_faulty_patterns_flat),
      .faulty_row_flat           (faulty_row_flat),
      .faulty_column_flat        (faulty_column_flat),
      .faulty_pe_count           (faulty_pe_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic           err;
      logic [7:0]     wt;
      logic [7:0]     act;
      logic [PSW-1:0] ps;
      logic [PSW-1:0] ans;
   } rd_exp_t;

   typedef struct {
      logic      ttype;
      logic      choose;
      logic [PW-1:0] idx;
      rd_exp_t   exp;
   } rd_vec_t;

   typedef struct {
      logic [1:0]     kind;
      logic           ttype;
      logic [2:0]     field;
      logic [PW-1:0]  addr;
      logic [PSW-1:0] data;
   } wr_vec_t;

   rd_exp_t exp_q[$];

   function automatic rd_exp_t mk(input logic err, input logic [7:0] wt, input logic [7:0] act,
                                  input logic [PSW-1:0] ps, input logic [PSW-1:0] ans);
      rd_exp_t e;
      e.err = err; e.wt = wt; e.act = act; e.ps = ps; e.ans = ans;
      return e;
   endfunction

   function automatic rd_vec_t rv(input logic ty, input logic ch, input logic [PW-1:0] idx, input rd_exp_t e);
      rd_vec_t v;
      v.ttype = ty; v.choose = ch; v.idx = idx; v.exp = e;
      return v;
   endfunction

   function automatic wr_vec_t wv(input logic ty, input logic [2:0] f, input logic [PW-1:0] a, input logic [PSW-1:0] d);
      wr_vec_t v;
      v.kind = 2'd0; v.ttype = ty; v.field = f; v.addr = a; v.data = d;
      return v;
   endfunction

   // Scoreboard: each rd_valid pops the expectation pushed when the read was driven.
   always @(negedge clk) begin
      rd_exp_t e;
      if (!rst && rd_valid) begin
         if (exp_q.size() == 0) begin
            check("rd_valid_unexpected", 64'(rd_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("rd_err",    64'(rd_err), 64'(e.err));
            check("rd_weight", 64'(scan_data_weight), 64'(e.wt));
            check("rd_act",    64'(scan_data_activation), 64'(e.act));
            check("rd_psum",   64'(scan_data_partial_sum_in), 64'(e.ps));
            check("rd_answer", 64'(scan_data_answer), 64'(e.ans));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!wr_ready && n < 50) begin
         tick();
         n++;
      end
      if (!wr_ready) check("wr_ready_timeout", 64'(wr_ready), 64'd1);
   endtask

   task automatic drive_wr(input logic [1:0] kind, input logic ty, input logic [2:0] fld,
                           input logic [PW-1:0] addr, input logic [PSW-1:0] data,
                           input logic [N-1:0] pe, input logic rf, input logic cf);
      wr_kind = kind; wr_type = ty; wr_field = fld; wr_addr = addr; wr_data = data;
      wr_pe_fault = pe; wr_row_fault = rf; wr_col_fault = cf;
   endtask

   task automatic do_write(input logic [1:0] kind, input logic ty, input logic [2:0] fld,
                           input logic [PW-1:0] addr, input logic [PSW-1:0] data,
                           input logic [N-1:0] pe, input logic rf, input logic cf);
      wait_ready();
      drive_wr(kind, ty, fld, addr, data, pe, rf, cf);
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      wait_ready();
   endtask

   task automatic do_read(input logic ty, input logic ch, input logic [PW-1:0] idx, input rd_exp_t e);
      test_type = ty; td_answer_choose = ch; test_counter = idx;
      rd_req = 1'b1;
      exp_q.push_back(e);
      tick();
      rd_req = 1'b0;
   endtask

   wr_vec_t wvec[16];
   rd_vec_t rvec[6];
   rd_exp_t sa3_old;
   logic [63:0] flat_exp;
   logic [7:0]  row_exp, col_exp;
   logic [6:0]  cnt_exp;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      wr_valid = 1'b0; rd_req = 1'b0; test_type = 1'b0; td_answer_choose = 1'b0; test_counter = '0;
      drive_wr(2'd0, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);

      wvec[0]  = wv(1'b0, 3'd0, 5'd3,  19'h7FF5A);  // truncates to 0x5A
      wvec[1]  = wv(1'b0, 3'd2, 5'd3,  19'h00011);
      wvec[2]  = wv(1'b0, 3'd4, 5'd3,  19'h00123);
      wvec[3]  = wv(1'b0, 3'd6, 5'd3,  19'h007FF);
      wvec[4]  = wv(1'b0, 3'd7, 5'd3,  19'h00001);  // SA ignores capture field
      wvec[5]  = wv(1'b0, 3'd1, 5'd3,  19'h000AA);  // SA ignores wt2
      wvec[6]  = wv(1'b0, 3'd0, 5'd19, 19'h000EE);  // out of range, must not alias
      wvec[7]  = wv(1'b1, 3'd0, 5'd17, 19'h00001);
      wvec[8]  = wv(1'b1, 3'd1, 5'd17, 19'h00002);
      wvec[9]  = wv(1'b1, 3'd2, 5'd17, 19'h00003);
      wvec[10] = wv(1'b1, 3'd3, 5'd17, 19'h00004);
      wvec[11] = wv(1'b1, 3'd4, 5'd17, 19'h00105);
      wvec[12] = wv(1'b1, 3'd5, 5'd17, 19'h00106);
      wvec[13] = wv(1'b1, 3'd6, 5'd17, 19'h00207);
      wvec[14] = wv(1'b1, 3'd7, 5'd17, 19'h00308);
      wvec[15] = wv(1'b1, 3'd6, 5'd18, 19'h00555);  // TD out of range

      sa3_old = mk(1'b0, 8'h5A, 8'h11, 19'h123, 19'h7FF);
      rvec[0] = rv(1'b0, 1'b0, 5'd3,  sa3_old);
      rvec[1] = rv(1'b1, 1'b0, 5'd17, mk(1'b0, 8'h02, 8'h04, 19'h106, 19'h207));
      rvec[2] = rv(1'b1, 1'b1, 5'd17, mk(1'b0, 8'h02, 8'h03, 19'h105, 19'h308));
      rvec[3] = rv(1'b1, 1'b0, 5'd18, mk(1'b1, 8'h00, 8'h00, 19'h0, 19'h0));
      rvec[4] = rv(1'b0, 1'b0, 5'd12, mk(1'b1, 8'h00, 8'h00, 19'h0, 19'h0));
      rvec[5] = rv(1'b1, 1'b1, 5'd31, mk(1'b1, 8'h00, 8'h00, 19'h0, 19'h0));

      // Reset state
      tick(); tick();
      check("rst_wr_ready", 64'(wr_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_err", 64'(rd_err), 64'd0);
      check("rst_weight", 64'(scan_data_weight), 64'd0);
      check("rst_answer", 64'(scan_data_answer), 64'd0);
      check("rst_pe_map", envm_faulty_patterns_flat, 64'd0);
      check("rst_rows", 64'(faulty_row_flat), 64'd0);
      check("rst_cols", 64'(faulty_column_flat), 64'd0);
      check("rst_count", 64'(faulty_pe_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // Pattern loads then back-to-back table reads
      for (int i = 0; i < 16; i++)
         do_write(wvec[i].kind, wvec[i].ttype, wvec[i].field, wvec[i].addr, wvec[i].data, '0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++)
         do_read(rvec[i].ttype, rvec[i].choose, rvec[i].idx, rvec[i].exp);
      tick(); tick();

      // Fault record timing: PROG_CYCLES + COMMIT busy cycles
      wait_ready();
      drive_wr(2'd1, 1'b0, 3'd0, 5'd2, '0, 8'h81, 1'b1, 1'b1);
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      for (int i = 0; i < PROG + 1; i++) begin
         check("busy_during_prog", 64'(busy), 64'd1);
         check("ready_during_prog", 64'(wr_ready), 64'd0);
         tick();
      end
      check("busy_after_commit", 64'(busy), 64'd0);
      check("ready_after_commit", 64'(wr_ready), 64'd1);
      check("pe_row2_after_commit", 64'(envm_faulty_patterns_flat[23:16]), 64'h81);
      check("rows_after_fault", 64'(faulty_row_flat), 64'h04);
      check("cols_after_fault", 64'(faulty_column_flat), 64'h04);
      check("count_not_yet", 64'(faulty_pe_count), 64'd0);
      tick();
      check("count_one_later", 64'(faulty_pe_count), 64'd2);

      do_write(2'd1, 1'b0, 3'd0, 5'd7, '0, 8'hFF, 1'b1, 1'b0);
      tick();
      check("count_row7", 64'(faulty_pe_count), 64'd10);

      // Second record to row 2 via an address with high bits set
      do_write(2'd1, 1'b0, 3'd0, 5'd10, '0, 8'h02, 1'b0, 1'b0);
`ifdef ENVM_FAULT_ACCUM_EN
      flat_exp = 64'hFF00_0000_0083_0000; row_exp = 8'h84; col_exp = 8'h04; cnt_exp = 7'd11;
`else
      flat_exp = 64'hFF00_0000_0002_0000; row_exp = 8'h80; col_exp = 8'h00; cnt_exp = 7'd9;
`endif
      do_write(2'd3, 1'b0, 3'd0, 5'd2, 19'h7FFFF, 8'hFF, 1'b1, 1'b1);  // reserved kind
      tick();
      check("pe_map_second_record", envm_faulty_patterns_flat, flat_exp);
      check("rows_second_record", 64'(faulty_row_flat), 64'(row_exp));
      check("cols_second_record", 64'(faulty_column_flat), 64'(col_exp));
      check("count_second_record", 64'(faulty_pe_count), 64'(cnt_exp));

      do_write(2'd2, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
      check("erase_pe_map", envm_faulty_patterns_flat, 64'd0);
      check("erase_rows", 64'(faulty_row_flat), 64'd0);
      check("erase_cols", 64'(faulty_column_flat), 64'd0);
      tick();
      check("erase_count", 64'(faulty_pe_count), 64'd0);

      // Reset in the middle of PROG aborts the pattern write
      wait_ready();
      drive_wr(2'd0, 1'b0, 3'd0, 5'd3, 19'h99, '0, 1'b0, 1'b0);
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      tick(); tick();
      check("busy_before_abort", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("abort_wr_ready", 64'(wr_ready), 64'd1);
      check("abort_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("abort_stays_idle", 64'(busy), 64'd0);
      do_read(1'b0, 1'b0, 5'd3, sa3_old);
      tick();

      // Read during COMMIT sees the old value; the following read sees the new one
      wait_ready();
      drive_wr(2'd0, 1'b0, 3'd0, 5'd3, 19'h66, '0, 1'b0, 1'b0);
      wr_valid = 1'b1;
      tick();
      wr_valid = 1'b0;
      for (int i = 0; i < PROG; i++) tick();
      check("busy_in_commit", 64'(busy), 64'd1);
      do_read(1'b0, 1'b0, 5'd3, sa3_old);
      do_read(1'b0, 1'b0, 5'd3, mk(1'b0, 8'h66, 8'h11, 19'h123, 19'h7FF));
      tick(); tick();

      check("reads_pending", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
